// File: rtl/xio_arb.sv
// Two-master round-robin arbiter and fixed-wait-state sequencer for 8-bit XSOC peripherals.
// Optional build macro XIO_ARB_LOCK_EN lets m0_lock_i pin tie priority on master 0.
module xio_arb #(
  parameter int NSEL = 8,
  parameter int WS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req_i,
  input  logic            m0_we_i,
  input  logic [7:0]      m0_addr_i,
  input  logic [7:0]      m0_wdata_i,
  input  logic            m0_lock_i,
  output logic            m0_ack_o,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [7:0]      m1_addr_i,
  input  logic [7:0]      m1_wdata_i,
  output logic            m1_ack_o,
  output logic [7:0]      rdata_o,
  output logic [NSEL-1:0] sel_o,
  output logic [4:0]      io_addr_o,
  output logic [7:0]      io_d_o,
  input  logic [7:0]      io_q_i,
  output logic            io_oe_o,
  output logic            io_we_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WS_C = 4'(WS);

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            gnt_q, gnt_d;    // owner of the current access: 1 = m1
  logic            last_q, last_d;  // last granted master: 1 = m1
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [NSEL-1:0] sel_q, sel_d;
  logic [4:0]      io_addr_q, io_addr_d;
  logic [7:0]      io_d_q, io_d_d;
  logic            io_oe_q, io_oe_d;
  logic            io_we_q, io_we_d;
  logic            m0_ack_q, m0_ack_d;
  logic            m1_ack_q, m1_ack_d;
  logic            lock_m0;

`ifdef XIO_ARB_LOCK_EN
  assign lock_m0 = m0_lock_i;
`else
  logic lock_unused;
  assign lock_unused = m0_lock_i;
  assign lock_m0     = 1'b0;
`endif

  // Indices at or beyond NSEL decode to an all-zero select.
  function automatic logic [NSEL-1:0] decode(input logic [2:0] idx);
    logic [NSEL-1:0] oh;
    oh = '0;
    for (int i = 0; i < NSEL; i++) begin
      if (idx == 3'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    sel_d     = '0;
    io_addr_d = io_addr_q;
    io_d_d    = io_d_q;
    io_oe_d   = 1'b0;
    io_we_d   = 1'b0;
    m0_ack_d  = 1'b0;
    m1_ack_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          gnt_d   = m1_req_i && (!m0_req_i || !last_q);
          we_d    = gnt_d ? m1_we_i    : m0_we_i;
          addr_d  = gnt_d ? m1_addr_i  : m0_addr_i;
          wdata_d = gnt_d ? m1_wdata_i : m0_wdata_i;
          cnt_d   = 4'd0;
          state_d = ACCESS;
          if (gnt_d || !lock_m0) last_d = gnt_d;
        end
      end
      ACCESS: begin
        if (cnt_q == WS_C) begin
          state_d = DONE;
          if (!we_q) rdata_d = io_q_i;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of what the next state will present.
    if (state_d == ACCESS) begin
      sel_d     = decode(addr_d[7:5]);
      io_addr_d = addr_d[4:0];
      if (we_d) io_d_d = wdata_d;
      io_oe_d   = !we_d;
      io_we_d   = we_d && (cnt_d == WS_C);
    end
    if (state_d == DONE) begin
      m0_ack_d = !gnt_d;
      m1_ack_d = gnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= 8'd0;
      wdata_q   <= 8'd0;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= 4'd0;
      rdata_q   <= 8'd0;
      sel_q     <= '0;
      io_addr_q <= 5'd0;
      io_d_q    <= 8'd0;
      io_oe_q   <= 1'b0;
      io_we_q   <= 1'b0;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      sel_q     <= sel_d;
      io_addr_q <= io_addr_d;
      io_d_q    <= io_d_d;
      io_oe_q   <= io_oe_d;
      io_we_q   <= io_we_d;
      m0_ack_q  <= m0_ack_d;
      m1_ack_q  <= m1_ack_d;
    end
  end

  assign rdata_o   = rdata_q;
  assign sel_o     = sel_q;
  assign io_addr_o = io_addr_q;
  assign io_d_o    = io_d_q;
  assign io_oe_o   = io_oe_q;
  assign io_we_o   = io_we_q;
  assign m0_ack_o  = m0_ack_q;
  assign m1_ack_o  = m1_ack_q;

endmodule
